load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Requester side of the data-memory port: the MEM-stage load/store unit.
//   - Accepts byte-addressed load/store requests from the EX/MEM stage.
//   - Drives the word-wide data memory through clk, rst, MW, memaddr,
//     datain and dataout.
//   - Returns zero/sign-extended load data to MEM/WB.
//   - Builds byte and halfword stores by read-modify-write, because the
//     memory writes whole words only.
// PARAMETERS
//   ADDR_W    6         word-index width of memaddr (memory depth 2**ADDR_W words)
//   MEM_BASE  32'h0     byte address of memory word 0
// PORTS
//   clk         in   1       clock; all state changes on posedge
//   rst         in   1       synchronous, active-high reset; shared with data memory
//   req_valid   in   1       request present
//   req_ready   out  1       unit can accept (combinational: state==IDLE)
//   req_we      in   1       1=store, 0=load
//   req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//   req_signed  in   1       loads: 1=sign-extend, 0=zero-extend
//   req_addr    in   32      byte address
//   req_wdata   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//   resp_valid  out  1       one-cycle response pulse; consumer always accepts
//   resp_rdata  out  32      extended load data; 0 for stores and errors
//   resp_err    out  1       misaligned/out-of-range/illegal-size request
//   MW          out  1       memory write enable
//   memaddr     out  ADDR_W  memory word index
//   datain      out  32      memory write data
//   dataout     in   32      memory read data (combinational from memaddr)
// BEHAVIOUR
//   States: IDLE, ACCESS, RMW_RD, WR, RESP. Handshake: accept when req_valid && req_ready.
//   On accept, latch the request and compute:
//     off = req_addr - MEM_BASE; idx = off[ADDR_W+1:2]; lane = off[1:0].
//   err=1 if any of: off >= 4*2**ADDR_W (unsigned); size 11;
//     half with lane[0]=1; word with lane!=0.
//   Transitions:
//     IDLE  -> RESP    if err
//     IDLE  -> ACCESS  if load
//     IDLE  -> WR      if store word
//     IDLE  -> RMW_RD  if store byte/half
//   ACCESS: capture dataout, extract lane (little-endian), extend -> RESP.
//   RMW_RD: capture dataout, merge wdata into the lane bytes -> WR.
//   WR: MW=1 for exactly this cycle with datain=merged/full word -> RESP.
//   RESP: resp_valid=1, resp_err and resp_rdata valid -> IDLE.
//   Latency from accept cycle T: error resp at T+1; load and word-store resp at T+2;
//     byte/half store resp at T+3. req_ready=0 from T+1 until after RESP.
//   A store commits to memory at the posedge ending the WR cycle.
//   A load issued after a store's RESP sees the new data.
//   Outputs outside their states:
//     MW=0 except WR; datain=0 except WR; memaddr=latched idx in ACCESS/RMW_RD/WR, else 0;
//     resp_valid=0 and resp_rdata=0 except RESP.
//   Error requests never assert MW and never touch memory contents.
//   Reset: state IDLE, all latches 0; after the rst cycle resp_valid=0, resp_err=0,
//     resp_rdata=0, MW=0, memaddr=0, datain=0, req_ready=1.
//   Reset mid-operation abandons the request with no response.
//   If rst coincides with WR, memory rst has priority and the write is lost.
//   The memory itself reloads word i = i on rst.
//   Unsigned offset compare makes addresses below MEM_BASE wrap large and return err.
// TESTING
//   1 rst; load word 0x14 unsigned -> resp at T+2, rdata=0x00000005, err=0, MW never 1
//   2 store word 0xDEADBEEF @0x20 -> T+1 MW=1 memaddr=8; resp T+2; reload -> 0xDEADBEEF
//   3 store byte 0xAB @0x0D -> T+1 memaddr=3 MW=0, T+2 MW=1 datain=0x0000AB03, resp T+3
//   4 after 3: lb signed @0x0D -> 0xFFFFFFAB; lbu -> 0x000000AB; lh signed @0x0C -> 0xFFFFAB03
//   5 lw @0x06 -> resp_err=1 at T+1, rdata=0; sw @0x100 -> err, MW stays 0, word 0 unchanged
//   6 rst during RMW_RD of a byte store -> no MW pulse, no resp_valid, req_ready=1 next cycle

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage. It takes byte-addressed load and store
// requests, drives a word-wide data memory, returns loads zero- or
// sign-extended, and builds byte/halfword stores by read-modify-write.
module load_store_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] MEM_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MW,
  output logic [ADDR_W-1:0] memaddr,
  output logic [31:0]       datain,
  input  logic [31:0]       dataout
);

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, WR, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  state_t state_reg, state_next;

  // Latched request
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       wr_word_reg;

  // Request decode, valid only while idle
  logic              accept;
  logic [31:0]       off;
  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_lane;
  logic              range_err;
  logic              req_err;

  assign accept    = req_valid && req_ready;
  assign off       = req_addr - MEM_BASE;
  assign req_idx   = off[ADDR_W+1:2];
  assign req_lane  = off[1:0];
  // Unsigned: addresses below MEM_BASE wrap to huge offsets and land here too.
  assign range_err = |off[31:ADDR_W+2];
  assign req_err   = range_err
                  || (req_size == SIZE_ILL)
                  || (req_size == SIZE_HALF && req_lane[0])
                  || (req_size == SIZE_WORD && req_lane != 2'b00);

  // Load lane extraction from the word currently on dataout (little-endian)
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Select the addressed byte/half and extend it to 32 bits
  always_comb begin
    lane_byte = dataout[{lane_reg, 3'b000} +: 8];
    lane_half = lane_reg[1] ? dataout[31:16] : dataout[15:0];
    load_ext  = dataout;
    case (size_reg)
      SIZE_BYTE: load_ext = {{24{signed_reg & lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_ext = {{16{signed_reg & lane_half[15]}}, lane_half};
      default:   load_ext = dataout;
    endcase
  end

  // Store merge: each byte lane takes new data if the store covers it,
  // otherwise keeps the byte just read from memory.
  logic [31:0] merged_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = (size_reg == SIZE_BYTE) ? (lane_reg == 2'(gi)) :
                        (size_reg == SIZE_HALF) ? (lane_reg[1] == 1'(gi / 2)) :
                                                  1'b1;
      assign lane_src = (size_reg == SIZE_BYTE) ? wdata_reg[7:0] :
                        (size_reg == SIZE_HALF) ? wdata_reg[8*(gi%2) +: 8] :
                                                  wdata_reg[8*gi +: 8];
      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : dataout[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and state-decoded memory/response outputs
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    MW         = 1'b0;
    datain     = 32'h0;
    memaddr    = '0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                  state_next = RESP;
          else if (!req_we)             state_next = ACCESS;
          else if (req_size == SIZE_WORD) state_next = WR;
          else                          state_next = RMW_RD;
        end
      end
      ACCESS: begin
        memaddr    = idx_reg;
        state_next = RESP;
      end
      RMW_RD: begin
        memaddr    = idx_reg;
        state_next = WR;
      end
      WR: begin
        memaddr    = idx_reg;
        MW         = 1'b1;
        datain     = wr_word_reg;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_err   = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, load capture and read-modify-write merge
  always_ff @(posedge clk) begin
    if (rst) begin
      size_reg    <= 2'b00;
      signed_reg  <= 1'b0;
      lane_reg    <= 2'b00;
      idx_reg     <= '0;
      wdata_reg   <= 32'h0;
      err_reg     <= 1'b0;
      rdata_reg   <= 32'h0;
      wr_word_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            size_reg    <= req_size;
            signed_reg  <= req_signed;
            lane_reg    <= req_lane;
            idx_reg     <= req_idx;
            wdata_reg   <= req_wdata;
            err_reg     <= req_err;
            rdata_reg   <= 32'h0;
            // A full-word store writes the request data unchanged.
            wr_word_reg <= req_wdata;
          end
        end
        ACCESS:  rdata_reg   <= load_ext;
        RMW_RD:  wr_word_reg <= merged_word;
        default: ;
      endcase
    end
  end

endmodule
